ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu.sv | 91 +++++++++
 tb/tb_ifu.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
//  Module   : ifu
//  Purpose  : Instruction fetch unit. Holds the program counter, reads the
//             instruction memory combinationally at the current PC, and
//             selects the next PC from sequential, branch and jump targets.
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  Module   : ifu_imem
//  Purpose  : Read-only instruction memory, word addressed, asynchronous read.
//             Contents are loaded by preload only; there is no write port.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module ifu_imem #(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic [IDX_W-1:0] i_word_idx,
    output logic [31:0]      o_rdata
);

    logic [31:0] mem [0:MEM_WORDS-1];

    // Asynchronous word read
    assign o_rdata = mem[i_word_idx];

endmodule

module ifu #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        start,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] instruction
);

    localparam int c_IDX_W = $clog2(MEM_WORDS);

    logic [31:0]        address;
    logic [c_IDX_W-1:0] w_word_idx;
    logic [31:0]        w_pc_plus4;
    logic [31:0]        w_branch_offset;
    logic [31:0]        w_branch_target;
    logic [31:0]        w_jump_target;
    logic               w_take_branch;
    logic [31:0]        w_next_pc;

    // Byte offset bits are dropped; bits above the memory depth wrap away.
    assign w_word_idx = address[c_IDX_W+1:2];

    ifu_imem #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (c_IDX_W)
    ) IMEM (
        .i_word_idx (w_word_idx),
        .o_rdata    (instruction)
    );

    assign w_pc_plus4      = address + 32'd4;
    assign w_branch_offset = {{14{instruction[15]}}, instruction[15:0], 2'b00};
    assign w_branch_target = w_pc_plus4 + w_branch_offset;
    assign w_jump_target   = {w_pc_plus4[31:28], instruction[25:0], 2'b00};
    assign w_take_branch   = branch & zero;

    // Next-PC select: jump outranks a taken branch, which outranks PC+4
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump) begin
            w_next_pc = w_jump_target;
        end else if (w_take_branch) begin
            w_next_pc = w_branch_target;
        end
    end

    // PC register; start low forces the reset PC immediately and holds it
    always_ff @(posedge clock or negedge start) begin
        if (!start) begin
            address <= RESET_PC;
        end else begin
            address <= w_next_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifu
//  Purpose  : Directed-vector bench for ifu with a queue-based scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifu;

    logic        clock = 1'b0;
    logic        start = 1'b1;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] instruction;

    ifu #(
        .MEM_WORDS (1024),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clock       (clock),
        .start       (start),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .instruction (instruction)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] instr;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   n_vec  = 0;
    int   n_miss = 0;

    // Monitor: each sample strobe pops one expectation and compares
    initial begin
        forever begin
            exp_t e;
            @(sample_ev);
            if (q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL scoreboard_underflow: sample with no expectation");
            end else begin
                e = q.pop_front();
                n_vec++;
                if (dut.address !== e.addr || instruction !== e.instr) begin
                    n_miss++;
                    $display("FAIL %s: got addr=%08h instr=%08h, expected addr=%08h instr=%08h",
                             e.name, dut.address, instruction, e.addr, e.instr);
                end
            end
        end
    end

    task automatic expect_now(input string name, input logic [31:0] a, input logic [31:0] i);
        q.push_back('{name, a, i});
        -> sample_ev;
        #0;
    endtask

    // One rising edge, then sample 1 time unit later
    task automatic step(input string name, input logic [31:0] a, input logic [31:0] i);
        @(posedge clock);
        #1;
        expect_now(name, a, i);
    endtask

    // Pulse start low between edges, release on a falling edge
    task automatic do_reset(input string name, input logic [31:0] i0);
        @(negedge clock);
        #1;
        start = 1'b0;
        #1;
        expect_now(name, 32'h0, i0);
        @(negedge clock);
        start = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 1024; k++) dut.IMEM.mem[k] = 32'h0;
        dut.IMEM.mem[0]  = 32'h1111_1111;
        dut.IMEM.mem[1]  = 32'h2222_2222;
        dut.IMEM.mem[2]  = 32'h3333_3333;
        dut.IMEM.mem[3]  = 32'h4444_4444;
        dut.IMEM.mem[5]  = 32'h5555_5555;
        dut.IMEM.mem[16] = 32'hAAAA_0040;

        // Sequential fetch, including an edge ignored while in reset
        @(negedge clock);
        start = 1'b0;
        #1;
        expect_now("reset_state", 32'h0, 32'h1111_1111);
        step("reset_hold_edge", 32'h0, 32'h1111_1111);
        @(negedge clock);
        start = 1'b1;
        step("seq_1", 32'h4, 32'h2222_2222);
        step("seq_2", 32'h8, 32'h3333_3333);
        step("seq_3", 32'hC, 32'h4444_4444);

        // Taken branch from PC=4: 8 + (3<<2) = 0x14
        dut.IMEM.mem[1] = 32'h1000_0003;
        do_reset("br_reset", 32'h1111_1111);
        step("br_at_4", 32'h4, 32'h1000_0003);
        branch = 1'b1; zero = 1'b1;
        step("br_taken", 32'h14, 32'h5555_5555);
        branch = 1'b0; zero = 1'b0;

        // Not-taken branch, then a jump pulse between edges that must be ignored
        do_reset("nt_reset", 32'h1111_1111);
        step("nt_at_4", 32'h4, 32'h1000_0003);
        branch = 1'b1; zero = 1'b0;
        step("br_not_taken", 32'h8, 32'h3333_3333);
        branch = 1'b0;
        #2 jump = 1'b1;
        #2 jump = 1'b0;
        step("mid_cycle_jump_ignored", 32'hC, 32'h4444_4444);

        // Negative offset at PC=0x10: 0x14 - 8 = 0x0C
        dut.IMEM.mem[4] = 32'h1000_FFFE;
        do_reset("neg_reset", 32'h1111_1111);
        step("neg_4",  32'h4,  32'h1000_0003);
        step("neg_8",  32'h8,  32'h3333_3333);
        step("neg_C",  32'hC,  32'h4444_4444);
        step("neg_10", 32'h10, 32'h1000_FFFE);
        branch = 1'b1; zero = 1'b1;
        step("br_negative", 32'hC, 32'h4444_4444);
        branch = 1'b0; zero = 1'b0;

        // Jump with a taken branch also asserted: jump wins, target 0x40
        dut.IMEM.mem[0] = 32'h0800_0010;
        do_reset("jmp_reset", 32'h0800_0010);
        jump = 1'b1; branch = 1'b1; zero = 1'b1;
        step("jump_priority", 32'h40, 32'hAAAA_0040);
        jump = 1'b0; branch = 1'b0; zero = 1'b0;

        // Asynchronous reset between edges, hold over 2 edges, resume at PC+4
        @(negedge clock);
        #2;
        start = 1'b0;
        #1;
        expect_now("async_reset_immediate", 32'h0, 32'h0800_0010);
        step("async_hold_1", 32'h0, 32'h0800_0010);
        step("async_hold_2", 32'h0, 32'h0800_0010);
        @(negedge clock);
        start = 1'b1;
        step("after_release", 32'h4, 32'h1000_0003);

        #2;
        if (q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_leftover: %0d expectations unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
